instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly downstream of the ProgramCounter. It drives the synchronous instruction ROM from CounterValue and tags each returning word with its address. Words are buffered in a small FIFO and handed to the decoder over a valid/ready handshake. The PC free-runs, so this block enforces back-pressure and branches through the PC's LoadValue/LoadEnable port. The top level ties the PC's OffsetEnable to 0.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, PC/address width; matches CounterValue

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
CounterValue  in  ADDR_WIDTH  current PC from ProgramCounter
MemAddr  out  ADDR_WIDTH  ROM read address; read data returns one cycle later
MemData  in  DATA_WIDTH  ROM read data for the previous cycle's MemAddr
Instr  out  DATA_WIDTH  instruction at FIFO head
InstrPc  out  ADDR_WIDTH  address of Instr
InstrValid  out  1  FIFO head valid
InstrReady  in  1  decoder accepts head
BranchValid  in  1  decoder redirect request, single-cycle pulse
BranchTarget  in  ADDR_WIDTH  redirect address
LoadValue  out  ADDR_WIDTH  to ProgramCounter LoadValue
LoadEnable  out  1  to ProgramCounter LoadEnable

Behaviour:
- Reset (async): FIFO empty, pointers 0, state RUN, pend_valid 0, pend_pc 0, replay_pc 0. Outputs: InstrValid 0, Instr 0, InstrPc 0, LoadEnable 0, LoadValue 0. The PC resets on the same signal.
- MemAddr = CounterValue (combinational, every cycle).
- In-flight tag: pend_valid/pend_pc registers mark whether next cycle's MemData is wanted. In RUN with no branch: pend_valid<=1, pend_pc<=CounterValue.
- Push: if pend_valid and no BranchValid, push {MemData, pend_pc} into the FIFO.
- Pop: InstrValid && InstrReady. Push and pop in the same cycle while full is allowed; count is unchanged. Pointers wrap modulo DEPTH.
- InstrValid = !empty. Instr/InstrPc come from the head register.
- States: RUN, HOLD.
- RUN, push attempted while full and no pop:
  - word dropped
  - same cycle: LoadEnable=1, LoadValue=pend_pc
  - replay_pc<=pend_pc, pend_valid<=0, next state HOLD
- HOLD, FIFO still full: LoadEnable=1, LoadValue=replay_pc, so the PC stays at replay_pc; pend_valid<=0.
- HOLD, count<DEPTH (registered count): LoadEnable=0, pend_valid<=1, pend_pc<=CounterValue (=replay_pc), next state RUN. Result: no gaps or duplicates in the InstrPc sequence.
- BranchValid has priority over everything:
  - same cycle: LoadEnable=1, LoadValue=BranchTarget
  - FIFO flushed at the edge; a pop handshaking in this cycle still completes first
  - pend_valid<=0, state<=RUN
- Branch latency: BranchValid in cycle t → InstrValid with InstrPc=BranchTarget in cycle t+3.
- Reset latency: first InstrValid (InstrPc=0) in the 2nd cycle after reset release (cycle 0 = first edge).
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; 0xFFFF→0x0000 needs no special case.
- Async reset during HOLD or a branch aborts immediately; no partial state survives.

Decomposition:
- Package fetch_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults
  - typedef fetch_entry_t {instr, pc}
  - typedef enum fetch_state_t {RUN, HOLD}
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty, count, head outputs.
- instruction_fetch holds the tag registers, the FSM and the load mux.

Test Plan:
1. ROM mem[a]=a^16'hA5A5, InstrReady=1, release reset → InstrValid in cycle 2. InstrPc 0,1,2,… consecutive, Instr=pc^A5A5. LoadEnable stays 0.
2. InstrReady=0 for 10 cycles from reset (DEPTH=4) → FIFO holds pc 0..3. LoadEnable=1 with LoadValue=4, held for the whole stall. Then InstrReady=1 → accepted pcs 0,1,2,3,4,5,… with no gap or duplicate.
3. With FIFO holding 2 entries, BranchValid, BranchTarget=0x0100 → LoadEnable=1, LoadValue=0x0100 that cycle. InstrValid=0 the next cycle. InstrValid with InstrPc=0x0100 three cycles after the pulse.
4. Branch to 0x0040 while in HOLD → LoadValue=0x0040, not replay_pc. Next accepted InstrPc=0x0040.
5. Assert Reset asynchronously mid-HOLD → InstrValid, LoadEnable, Instr, InstrPc all 0 before the next clock edge. Normal restart at pc 0.
6. Branch to 0xFFFE, InstrReady=1 → InstrPc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FIFO entry type and FSM states for the fetch stage
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 16;
    localparam int FETCH_ADDR_WIDTH = 16;

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] instr;
        logic [FETCH_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of tagged instruction words with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: ROM addressing, word tagging, buffering and PC redirect
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] CounterValue,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [ADDR_WIDTH-1:0] InstrPc,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    input  logic                  BranchValid,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    output logic [ADDR_WIDTH-1:0] LoadValue,
    output logic                  LoadEnable
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state_q;
    logic                  pend_valid_q;
    logic [ADDR_WIDTH-1:0] pend_pc_q;
    logic [ADDR_WIDTH-1:0] replay_pc_q;

    fetch_entry_t          push_entry;
    fetch_entry_t          head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  pop;
    logic                  push_try;
    logic                  overflow;
    logic                  push;
    logic                  has_room;

    assign MemAddr    = CounterValue;
    assign InstrValid = !fifo_empty;
    assign Instr      = head.instr;
    assign InstrPc    = head.pc;

    assign pop        = InstrValid && InstrReady;
    assign push_try   = pend_valid_q && !BranchValid;
    assign overflow   = (state_q == RUN) && push_try && fifo_full && !pop;
    assign push       = push_try && !overflow;
    assign has_room   = (fifo_count < CW'(DEPTH));
    assign push_entry = '{instr: MemData, pc: pend_pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (Clock),
        .rst         (Reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (BranchValid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    // The PC free-runs, so every stall or redirect must be applied through its load port this cycle.
    always_comb begin
        LoadEnable = 1'b0;
        LoadValue  = '0;
        if (BranchValid) begin
            LoadEnable = 1'b1;
            LoadValue  = BranchTarget;
        end else if (overflow) begin
            LoadEnable = 1'b1;
            LoadValue  = pend_pc_q;
        end else if ((state_q == HOLD) && fifo_full) begin
            LoadEnable = 1'b1;
            LoadValue  = replay_pc_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            replay_pc_q  <= '0;
        end else if (BranchValid) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (overflow) begin
                        replay_pc_q  <= pend_pc_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= HOLD;
                    end else begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= CounterValue;
                    end
                end
                HOLD: begin
                    if (has_room) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= CounterValue;
                        state_q      <= RUN;
                    end else begin
                        pend_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= RUN;
                    pend_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench with PC/ROM environment and stream reference model
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_q;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] load_value;
    logic        load_enable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(4), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .CounterValue (pc_q),
        .MemAddr      (mem_addr),
        .MemData      (mem_data),
        .Instr        (instr),
        .InstrPc      (instr_pc),
        .InstrValid   (instr_valid),
        .InstrReady   (instr_ready),
        .BranchValid  (branch_valid),
        .BranchTarget (branch_target),
        .LoadValue    (load_value),
        .LoadEnable   (load_enable)
    );

    // Free-running program counter and synchronous ROM surrounding the fetch stage.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_q <= 16'h0000;
        else if (load_enable) pc_q <= load_value;
        else pc_q <= pc_q + 16'h0001;
    end

    always @(posedge clk) mem_data <= mem_addr ^ 16'hA5A5;

    task automatic do_reset();
        rst = 1'b1;
        branch_valid = 1'b0;
        branch_target = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the next accepted word; called at a negedge with inputs already set.
    task automatic next_accept(output logic ok, output logic [15:0] pc, output logic [15:0] ins);
        ok = 1'b0;
        pc = '0;
        ins = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (instr_valid && instr_ready) begin
                ok = 1'b1;
                pc = instr_pc;
                ins = instr;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (load_enable !== 1'b0) begin errors++; $display("FAIL reset_load_enable got %0b want 0", load_enable); end
        checks++; if (load_value !== 16'h0) begin errors++; $display("FAIL reset_load_value got %h want 0000", load_value); end
        checks++; if (instr !== 16'h0 || instr_pc !== 16'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0000/0000", instr, instr_pc); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_latency_early got %0b want 0", instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
            errors++; $display("FAIL reset_latency_first got valid %0b pc %h want 1 0000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        int got;
        int le_bad;
        instr_ready = 1'b1;
        do_reset();
        exp_pc = 16'h0;
        got = 0;
        le_bad = 0;
        for (int i = 0; i < 40 && got < 20; i++) begin
            #1;
            if (load_enable !== 1'b0) le_bad++;
            if (instr_valid && instr_ready) begin
                checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc got %h want %h", instr_pc, exp_pc); end
                checks++; if (instr !== (exp_pc ^ 16'hA5A5)) begin errors++; $display("FAIL stream_instr got %h want %h", instr, exp_pc ^ 16'hA5A5); end
                exp_pc++;
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 20) begin errors++; $display("FAIL stream_count got %0d want 20", got); end
        checks++; if (le_bad != 0) begin errors++; $display("FAIL stream_load_enable got %0d asserted cycles want 0", le_bad); end
    endtask

    task automatic test_stall();
        logic ok;
        logic [15:0] pc;
        logic [15:0] ins;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (i >= 6) begin
                checks++; if (load_enable !== 1'b1 || load_value !== 16'h0004) begin
                    errors++; $display("FAIL stall_hold cycle %0d got le %0b lv %h want 1 0004", i, load_enable, load_value);
                end
            end
        end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
            errors++; $display("FAIL stall_head got valid %0b pc %h want 1 0000", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            next_accept(ok, pc, ins);
            checks++; if (!ok || pc !== 16'(k) || ins !== (16'(k) ^ 16'hA5A5)) begin
                errors++; $display("FAIL stall_release idx %0d got ok %0b pc %h instr %h want pc %h", k, ok, pc, ins, 16'(k));
            end
        end
    endtask

    task automatic test_branch();
        instr_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
            errors++; $display("FAIL branch_pre got valid %0b pc %h want 1 0000", instr_valid, instr_pc);
        end
        branch_valid = 1'b1;
        branch_target = 16'h0100;
        #1;
        checks++; if (load_enable !== 1'b1 || load_value !== 16'h0100) begin
            errors++; $display("FAIL branch_load got le %0b lv %h want 1 0100", load_enable, load_value);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_flush got valid %0b want 0", instr_valid); end
        @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_t2 got valid %0b want 0", instr_valid); end
        @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin
            errors++; $display("FAIL branch_t3 got valid %0b pc %h want 1 0100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_branch_hold();
        logic ok;
        logic [15:0] pc;
        logic [15:0] ins;
        instr_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        branch_valid = 1'b1;
        branch_target = 16'h0040;
        #1;
        checks++; if (load_enable !== 1'b1 || load_value !== 16'h0040) begin
            errors++; $display("FAIL hold_branch_load got le %0b lv %h want 1 0040", load_enable, load_value);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_accept(ok, pc, ins);
            checks++; if (!ok || pc !== (16'h0040 + 16'(k))) begin
                errors++; $display("FAIL hold_branch_seq idx %0d got ok %0b pc %h want %h", k, ok, pc, 16'h0040 + 16'(k));
            end
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        logic [15:0] pc;
        logic [15:0] ins;
        instr_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || load_enable !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
            errors++; $display("FAIL async_reset got valid %0b le %0b instr %h pc %h want all 0", instr_valid, load_enable, instr, instr_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_accept(ok, pc, ins);
            checks++; if (!ok || pc !== 16'(k)) begin
                errors++; $display("FAIL async_restart idx %0d got ok %0b pc %h want %h", k, ok, pc, 16'(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic ok;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] exp_seq [4];
        exp_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        instr_ready = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        branch_valid = 1'b1;
        branch_target = 16'hFFFE;
        @(negedge clk);
        branch_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_accept(ok, pc, ins);
            checks++; if (!ok || pc !== exp_seq[k] || ins !== (exp_seq[k] ^ 16'hA5A5)) begin
                errors++; $display("FAIL wrap_seq idx %0d got ok %0b pc %h instr %h want pc %h", k, ok, pc, ins, exp_seq[k]);
            end
        end
    endtask

    // Random ready/branch traffic: accepted words must form a gap-free address stream per branch target.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] last_target;
        int since_branch;
        int accepted;
        int ready_pct;
        instr_ready = 1'b1;
        do_reset();
        exp_pc = 16'h0;
        last_target = 16'h0;
        since_branch = 100;
        accepted = 0;
        ready_pct = 80;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 32 == 0) ready_pct = ($urandom_range(0, 1) == 0) ? 20 : 90;
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            branch_valid = ($urandom_range(0, 29) == 0);
            branch_target = 16'($urandom);
            since_branch++;
            #1;
            if (since_branch == 3) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== last_target) begin
                    errors++; $display("FAIL rand_branch_latency got valid %0b pc %h want 1 %h", instr_valid, instr_pc, last_target);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++; if (instr_pc !== exp_pc || instr !== (exp_pc ^ 16'hA5A5)) begin
                    errors++; $display("FAIL rand_seq got pc %h instr %h want pc %h", instr_pc, instr, exp_pc);
                end
                exp_pc++;
                accepted++;
            end
            if (branch_valid) begin
                checks++; if (load_enable !== 1'b1 || load_value !== branch_target) begin
                    errors++; $display("FAIL rand_branch_load got le %0b lv %h want 1 %h", load_enable, load_value, branch_target);
                end
                exp_pc = branch_target;
                last_target = branch_target;
                since_branch = 0;
            end
            @(negedge clk);
        end
        branch_valid = 1'b0;
        checks++; if (accepted < 150) begin errors++; $display("FAIL rand_progress got %0d accepted want >= 150", accepted); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_hold();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
